// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and encodings for the decode-stage hazard sequencer.
package pipeline_hazard_controller_pkg;

   localparam int unsigned REG_W = 4;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_MEMWAIT = 2'b01,
      ST_DRAIN   = 2'b10
   } ctrl_state_t;

   localparam logic [1:0] FT_REG    = 2'b00;
   localparam logic [1:0] FT_MEM    = 2'b01;
   localparam logic [1:0] FT_BRANCH = 2'b10;
   localparam logic [1:0] FT_KERNEL = 2'b11;

   localparam logic [1:0] FC_LDR     = 2'b00;
   localparam logic [1:0] FC_STR     = 2'b01;
   localparam logic [1:0] FC_CACHEWR = 2'b10;

   localparam logic [REG_W-1:0] ZERO_REG = 4'd15;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side signals of the hazard controller; the controller is the slave.
interface pipeline_hazard_controller_if #(
   parameter int unsigned CNT_W = 16
);
   import pipeline_hazard_controller_pkg::*;

   logic             id_valid;
   logic [1:0]       id_funtype;
   logic [1:0]       id_funcode;
   logic [REG_W-1:0] id_ropa;
   logic [REG_W-1:0] id_ropb;
   logic             id_ropa_is_reg;
   logic             id_ropb_is_reg;
   logic [REG_W-1:0] id_rd;
   logic             ex_valid;
   logic             ex_memrd;
   logic [REG_W-1:0] ex_rd;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;

   logic             pc_we;
   logic             ifid_we;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             exmem_hold;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_valid, id_funtype, id_funcode, id_ropa, id_ropb,
             id_ropa_is_reg, id_ropb_is_reg, id_rd, ex_valid, ex_memrd,
             ex_rd, branch_taken, mem_req, mem_ready,
      input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold,
             state_o, stall_cycles
   );

   modport slave (
      input  id_valid, id_funtype, id_funcode, id_ropa, id_ropb,
             id_ropa_is_reg, id_ropb_is_reg, id_rd, ex_valid, ex_memrd,
             ex_rd, branch_taken, mem_req, mem_ready,
      output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold,
             state_o, stall_cycles
   );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Combinational load-use compare between decode operands and an in-flight load.
module load_use_detect
   import pipeline_hazard_controller_pkg::*;
(
   input  logic             id_valid,
   input  logic [1:0]       id_funtype,
   input  logic [1:0]       id_funcode,
   input  logic [REG_W-1:0] id_ropa,
   input  logic [REG_W-1:0] id_ropb,
   input  logic             id_ropa_is_reg,
   input  logic             id_ropb_is_reg,
   input  logic [REG_W-1:0] id_rd,
   input  logic             ex_valid,
   input  logic             ex_memrd,
   input  logic [REG_W-1:0] ex_rd,
   output logic             luse
);

   logic id_is_store;
   logic any_match;

   assign id_is_store = (id_funtype == FT_MEM) && (id_funcode == FC_STR);

   // Store data is read through RD, so it counts as a source operand.
   assign any_match = (id_ropa_is_reg && (id_ropa == ex_rd))
                   || (id_ropb_is_reg && (id_ropb == ex_rd))
                   || (id_is_store    && (id_rd   == ex_rd));

   assign luse = id_valid && ex_valid && ex_memrd && (ex_rd != ZERO_REG) && any_match;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage sequencer: load-use bubbles, memory-wait freeze, branch flush,
// cache-write drain and a saturating stall-cycle counter.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 16
) (
   input logic                          clk,
   input logic                          rst,
   pipeline_hazard_controller_if.slave  bus
);

   localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

   ctrl_state_t      state_q, state_d;
   logic [DW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_q;

   logic luse, mwait, cwr;
   logic pc_we_c, ifid_we_c, ifid_flush_c, idex_bubble_c, exmem_hold_c;

   load_use_detect u_luse (
      .id_valid       (bus.id_valid),
      .id_funtype     (bus.id_funtype),
      .id_funcode     (bus.id_funcode),
      .id_ropa        (bus.id_ropa),
      .id_ropb        (bus.id_ropb),
      .id_ropa_is_reg (bus.id_ropa_is_reg),
      .id_ropb_is_reg (bus.id_ropb_is_reg),
      .id_rd          (bus.id_rd),
      .ex_valid       (bus.ex_valid),
      .ex_memrd       (bus.ex_memrd),
      .ex_rd          (bus.ex_rd),
      .luse           (luse)
   );

   assign mwait = bus.mem_req && !bus.mem_ready;
   assign cwr   = bus.id_valid && (bus.id_funtype == FT_KERNEL) && (bus.id_funcode == FC_CACHEWR);

   // State, drain counter and stall counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (!pc_we_c && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      end
   end

   // Next state and same-cycle pipeline controls.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_we_c       = 1'b1;
      ifid_we_c     = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_bubble_c = 1'b0;
      exmem_hold_c  = 1'b0;

      case (state_q)
         ST_RUN, ST_MEMWAIT: begin
            if (mwait) begin
               pc_we_c      = 1'b0;
               ifid_we_c    = 1'b0;
               exmem_hold_c = 1'b1;
               state_d      = ST_MEMWAIT;
            end else if (luse) begin
               pc_we_c       = 1'b0;
               ifid_we_c     = 1'b0;
               idex_bubble_c = 1'b1;
               state_d       = ST_RUN;
            end else if (cwr) begin
               pc_we_c       = 1'b0;
               ifid_we_c     = 1'b0;
               idex_bubble_c = 1'b1;
               cnt_d         = DW'(DRAIN_CYCLES - 1);
               state_d       = ST_DRAIN;
            end else begin
               ifid_flush_c = bus.branch_taken;
               state_d      = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (mwait) begin
               pc_we_c       = 1'b0;
               ifid_we_c     = 1'b0;
               idex_bubble_c = 1'b1;
               exmem_hold_c  = 1'b1;
            end else if (cnt_q != '0) begin
               pc_we_c       = 1'b0;
               ifid_we_c     = 1'b0;
               idex_bubble_c = 1'b1;
               cnt_d         = cnt_q - DW'(1);
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Reset forces a safe frozen pipe regardless of state.
      if (rst) begin
         pc_we_c       = 1'b0;
         ifid_we_c     = 1'b0;
         ifid_flush_c  = 1'b0;
         idex_bubble_c = 1'b1;
         exmem_hold_c  = 1'b0;
      end
   end

   assign bus.pc_we        = pc_we_c;
   assign bus.ifid_we      = ifid_we_c;
   assign bus.ifid_flush   = ifid_flush_c;
   assign bus.idex_bubble  = idex_bubble_c;
   assign bus.exmem_hold   = exmem_hold_c;
   assign bus.state_o      = state_q;
   assign bus.stall_cycles = stall_q;

endmodule
